// File: rtl/gen_step_ctrl.sv
// Generation-step controller: turns interval-timer ticks or a single-step
// button into a 4-phase req/ack handshake with the life array.
module gen_step_ctrl #(
    parameter int GEN_W       = 16,
    parameter int TICK_DIV    = 1,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             run,
    input  logic             step_btn,
    input  logic             clr,
    input  logic             step_ack,
    output logic             step_req,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic             overrun,
    output logic             timeout
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W  = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("gen_step_ctrl: TICK_DIV must be >= 1");
    end
    if (ACK_TIMEOUT < 2) begin : g_bad_ack_timeout
        $error("gen_step_ctrl: ACK_TIMEOUT must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [TO_W-1:0]  to_cnt;
    logic             div_wrap;
    logic             launch;

    assign div_wrap = tick && (div == DIV_LAST);
    assign launch   = run ? div_wrap : step_btn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_req  <= 1'b0;
            busy      <= 1'b0;
            gen_count <= '0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            div       <= '0;
            to_cnt    <= '0;
        end else begin
            if (clr) begin
                div <= '0;
            end else if (run && tick) begin
                div <= div_wrap ? '0 : div + DIV_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (launch) begin
                        state    <= REQ;
                        step_req <= 1'b1;
                        busy     <= 1'b1;
                        to_cnt   <= '0;
                    end
                end
                REQ: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    // An ack on the expiry cycle still counts as a success.
                    if (step_ack) begin
                        state     <= RELEASE;
                        step_req  <= 1'b0;
                        gen_count <= gen_count + GEN_W'(1);
                    end else if (to_cnt == TO_LAST) begin
                        state    <= RELEASE;
                        step_req <= 1'b0;
                        timeout  <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!step_ack) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        to_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    step_req <= 1'b0;
                    busy     <= 1'b0;
                    to_cnt   <= '0;
                end
            endcase

            if (launch && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            // Clear wins over any same-cycle count or flag update.
            if (clr) begin
                gen_count <= '0;
                overrun   <= 1'b0;
                timeout   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gen_step_ctrl.sv
// Directed bench for gen_step_ctrl: expected values are queued as stimulus
// is applied and popped when the corresponding output is sampled.
module tb_gen_step_ctrl;

    localparam int GEN_W = 4;

    logic             clk;
    logic             rst_n;
    logic             tick;
    logic             run;
    logic             step_btn;
    logic             clr;
    logic             step_ack;
    logic             ack_man;
    logic             ack_auto;
    logic             step_req;
    logic             busy;
    logic [GEN_W-1:0] gen_count;
    logic             overrun;
    logic             timeout;

    int               n_chk;
    int               n_fail;
    int               auto_ack;
    int               rises;
    int               r0;
    logic             req_q;
    logic [GEN_W-1:0] gen_m;
    logic [31:0]      exp_q[$];

    assign step_ack = ack_man | ack_auto;

    gen_step_ctrl #(
        .GEN_W      (GEN_W),
        .TICK_DIV   (3),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .run      (run),
        .step_btn (step_btn),
        .clr      (clr),
        .step_ack (step_ack),
        .step_req (step_req),
        .busy     (busy),
        .gen_count(gen_count),
        .overrun  (overrun),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges of step_req, seen one edge late.
    initial begin
        rises = 0;
        req_q = 1'b0;
        forever begin
            @(posedge clk);
            if (step_req && !req_q) rises++;
            req_q = step_req;
        end
    end

    // Array model: raises ack auto_ack cycles after req, drops it once req falls.
    initial begin
        ack_auto = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack != 0 && step_req && !ack_auto) begin
                repeat (auto_ack - 1) begin
                    @(posedge clk);
                    #1;
                end
                ack_auto = 1'b1;
                for (int k = 0; k < 64 && step_req; k++) begin
                    @(posedge clk);
                    #1;
                end
                ack_auto = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic want(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        auto_ack = 0;
        gen_m    = '0;
        rst_n    = 1'b0;
        tick     = 1'b0;
        run      = 1'b0;
        step_btn = 1'b0;
        clr      = 1'b0;
        ack_man  = 1'b0;

        #12;
        want(0); chk("rst_req", step_req);
        want(0); chk("rst_busy", busy);
        want(0); chk("rst_gen", gen_count);
        want(0); chk("rst_ovr", overrun);
        want(0); chk("rst_to", timeout);
        rst_n = 1'b1;
        step();

        // Free-run, divide by 3, array acks 2 cycles after req.
        run      = 1'b1;
        auto_ack = 2;
        r0       = rises;
        for (int i = 1; i <= 9; i++) begin
            tick = 1'b1;
            want((i % 3) == 0);
            step();
            chk("run_req", step_req);
            tick = 1'b0;
            step();
        end
        repeat (4) step();
        gen_m = gen_m + 4'd3;
        want(3);     chk("run_rises", rises - r0);
        want(gen_m); chk("run_gen", gen_count);
        want(0);     chk("run_ovr", overrun);
        auto_ack = 0;
        run      = 1'b0;
        step();

        // Paused single step; ack one cycle after req.
        step_btn = 1'b1;
        want(1); step(); chk("pause_req0", step_req);
        step_btn = 1'b0;
        want(1); step(); chk("pause_req1", step_req);
        ack_man = 1'b1;
        gen_m   = gen_m + 4'd1;
        want(0);     step(); chk("pause_req2", step_req);
        want(gen_m); chk("pause_gen", gen_count);
        want(1);     chk("pause_busy_rel", busy);
        ack_man = 1'b0;
        want(0); step(); chk("pause_busy_idle", busy);
        tick = 1'b1;
        want(0); step(); chk("pause_tick_req", step_req);
        tick = 1'b0;
        want(0); step(); chk("pause_tick_busy", busy);

        // Overrun: extra launch while waiting for ack.
        run  = 1'b1;
        tick = 1'b1;
        step();
        step();
        want(1); step(); chk("ovr_req", step_req);
        repeat (2) step();
        want(1); step(); chk("ovr_flag", overrun);
        want(1); chk("ovr_req_still", step_req);
        tick    = 1'b0;
        ack_man = 1'b1;
        gen_m   = gen_m + 4'd1;
        want(0);     step(); chk("ovr_req_done", step_req);
        want(gen_m); chk("ovr_gen", gen_count);
        ack_man = 1'b0;
        run     = 1'b0;
        want(1); step(); chk("ovr_sticky", overrun);
        clr   = 1'b1;
        gen_m = '0;
        step();
        clr = 1'b0;
        want(0); chk("clr_gen", gen_count);
        want(0); chk("clr_ovr", overrun);

        // Timeout: no ack at all.
        step_btn = 1'b1;
        step();
        step_btn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            want(1);
            chk("to_req_hi", step_req);
            step();
        end
        want(0);     chk("to_req_lo", step_req);
        want(1);     chk("to_flag", timeout);
        want(gen_m); chk("to_gen", gen_count);
        want(1);     chk("to_busy_rel", busy);
        want(0); step(); chk("to_busy_idle", busy);
        clr = 1'b1;
        step();
        clr = 1'b0;
        want(0); chk("to_clr", timeout);

        // Ack arriving on the expiry cycle wins.
        step_btn = 1'b1;
        step();
        step_btn = 1'b0;
        repeat (7) step();
        want(1); chk("late_req", step_req);
        ack_man = 1'b1;
        gen_m   = gen_m + 4'd1;
        want(0);     step(); chk("late_req_lo", step_req);
        want(gen_m); chk("late_gen", gen_count);
        want(0);     chk("late_to", timeout);
        ack_man = 1'b0;
        step();

        // 16 steps on a 4-bit counter wrap back to zero.
        clr = 1'b1;
        step();
        clr   = 1'b0;
        gen_m = '0;
        for (int i = 0; i < 16; i++) begin
            step_btn = 1'b1;
            step();
            step_btn = 1'b0;
            ack_man  = 1'b1;
            gen_m    = gen_m + 4'd1;
            want(gen_m);
            step();
            chk("wrap_gen", gen_count);
            ack_man = 1'b0;
            step();
        end
        want(0); chk("wrap_zero", gen_count);

        // Clear on the ack cycle: clear wins, handshake still moves on.
        step_btn = 1'b1;
        step();
        step();
        step_btn = 1'b0;
        want(1); chk("clrack_ovr_set", overrun);
        ack_man = 1'b1;
        clr     = 1'b1;
        gen_m   = '0;
        step();
        clr = 1'b0;
        want(0); chk("clrack_gen", gen_count);
        want(0); chk("clrack_ovr", overrun);
        want(0); chk("clrack_to", timeout);
        want(0); chk("clrack_req", step_req);
        want(1); chk("clrack_busy", busy);
        ack_man = 1'b0;
        want(0); step(); chk("clrack_idle", busy);

        // Async reset in the middle of a handshake.
        step_btn = 1'b1;
        step();
        step_btn = 1'b0;
        ack_man  = 1'b1;
        step();
        ack_man = 1'b0;
        step();
        step_btn = 1'b1;
        step();
        step_btn = 1'b0;
        want(1); chk("ar_req_pre", step_req);
        #2;
        rst_n = 1'b0;
        #1;
        want(0); chk("ar_req", step_req);
        want(0); chk("ar_busy", busy);
        want(0); chk("ar_gen", gen_count);
        ack_man = 1'b1;
        step();
        step();
        #3;
        rst_n = 1'b1;
        repeat (3) step();
        want(0); chk("ar_stale_req", step_req);
        want(0); chk("ar_stale_busy", busy);
        step_btn = 1'b1;
        want(1); step(); chk("ar_launch", step_req);
        step_btn = 1'b0;
        want(0); step(); chk("ar_stale_ack", step_req);
        want(1); chk("ar_gen_after", gen_count);
        ack_man = 1'b0;
        want(0); step(); chk("ar_idle", busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
